// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register addresses, ExcCode values, Status/Cause bit
// positions and MTC0 write masks. Shared with the decode and WB stages.
package cp0_pkg;

  // {rd[4:0], sel[2:0]}
  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LSB  = 8;
  localparam int CAUSE_TI_BIT   = 30;
  localparam int CAUSE_BD_BIT   = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with half-rate tick and the TI flag.
// TI only fires after Count has differed from Compare at least once since
// reset, so the reset state Count==Compare==0 does not raise it until the
// first wrap.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_wen,
  input  logic        compare_wen,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tick;
  logic armed;

  // Count/Compare update, TI set on match and clear on Compare write
  always_ff @(posedge clk) begin
    if (reset) begin
      tick    <= 1'b0;
      armed   <= 1'b0;
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      if (count_wen) begin
        count <= wdata;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick) count <= count + 32'd1;
      end
      if (compare_wen) compare <= wdata;
      if (count != compare) armed <= 1'b1;
      if (compare_wen) ti <= 1'b0;
      else if (armed && (count == compare)) ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS32 CP0 responder (BadVAddr, Count, Compare, Status,
// Cause, EPC). Optional timer built when CP0_TIMER_EN is defined; otherwise
// Count/Compare read 0 and TI is tied low.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          HW_INT_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          cp0_addr,
  input  logic                cp0_wen,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  input  logic                ex_valid,
  input  logic [4:0]          ex_code,
  input  logic [31:0]         ex_pc,
  input  logic                ex_bd,
  input  logic [31:0]         ex_badvaddr,
  input  logic                eret,
  input  logic [HW_INT_W-1:0] hw_int,
  output logic [31:0]         epc_out,
  output logic                int_pending
);

  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        cause_bd;
  logic [4:0]  cause_exc;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic [31:0] cause_val;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        wr_en;

  // an exception or ERET in the same cycle drops the MTC0
  assign wr_en = cp0_wen & ~ex_valid & ~eret;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .count_wen   (wr_en && (cp0_addr == CP0_COUNT)),
    .compare_wen (wr_en && (cp0_addr == CP0_COMPARE)),
    .wdata       (cp0_wdata),
    .count       (count),
    .compare     (compare),
    .ti          (ti)
  );
`else
  assign count   = 32'd0;
  assign compare = 32'd0;
  assign ti      = 1'b0;
`endif

  // architectural state: exception commit > eret > MTC0
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= STATUS_RST;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      cause_bd   <= 1'b0;
      cause_exc  <= 5'd0;
      ip_sw      <= 2'd0;
      ip_hw      <= 6'd0;
    end else begin
      ip_hw <= {hw_int[5] | ti, hw_int[4:0]};
      if (ex_valid) begin
        status_q[STATUS_EXL_BIT] <= 1'b1;
        cause_exc <= ex_code;
        if (!status_q[STATUS_EXL_BIT]) begin
          epc_q    <= ex_bd ? ex_pc - 32'd4 : ex_pc;
          cause_bd <= ex_bd;
        end
        if ((ex_code == EXC_ADEL) || (ex_code == EXC_ADES))
          badvaddr_q <= ex_badvaddr;
      end else if (eret) begin
        status_q[STATUS_EXL_BIT] <= 1'b0;
      end else if (cp0_wen) begin
        case (cp0_addr)
          CP0_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
          CP0_CAUSE:  ip_sw    <= cp0_wdata[9:8];
          CP0_EPC:    epc_q    <= cp0_wdata;
          default:    ;
        endcase
      end
    end
  end

  assign cause_val = {cause_bd, ti, 14'd0, ip_hw, ip_sw, 1'b0, cause_exc, 2'b00};

  // zero-latency MFC0 read mux
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS:   cp0_rdata = status_q;
      CP0_CAUSE:    cp0_rdata = cause_val;
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out     = epc_q;
  assign int_pending = status_q[STATUS_IE_BIT] & ~status_q[STATUS_EXL_BIT] &
                       (|({ip_hw, ip_sw} & status_q[STATUS_IM_LSB +: 8]));

endmodule
